// File: rtl/ticket_sequencer_if.sv
// Bundle of request, coin and issue signals between the ticket front panel,
// the sequencer and the change-processing datapath.
interface ticket_sequencer_if;
  logic       start;
  logic [1:0] dest_sel;
  logic [1:0] qua_sel;
  logic       sel_valid;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       cancel;
  logic       act_1;

  logic [1:0] destination_in;
  logic [1:0] qua_in;
  logic [3:0] cost_in;
  logic [3:0] coin_in;
  logic       finish;
  logic [3:0] refund;
  logic       refund_valid;
  logic       coin_reject;
  logic       busy;
  logic [2:0] state;

  // Handshake: start, sel_valid and coin_valid are single-cycle strobes that
  // are acted on only in the state that consumes them; there is no ready.
  // finish is a level held from ISSUE until act_1 is sampled high in WAIT_ACK.
  // refund and coin_reject are one-cycle results qualified by refund_valid
  // and by the coin_reject pulse itself.
  modport slave (
    input  start, dest_sel, qua_sel, sel_valid, coin_valid, coin_value,
           cancel, act_1,
    output destination_in, qua_in, cost_in, coin_in, finish, refund,
           refund_valid, coin_reject, busy, state
  );

  modport master (
    output start, dest_sel, qua_sel, sel_valid, coin_valid, coin_value,
           cancel, act_1,
    input  destination_in, qua_in, cost_in, coin_in, finish, refund,
           refund_valid, coin_reject, busy, state
  );
endinterface

// File: rtl/ticket_sequencer.sv
// Ticket vending sequencer: selection, coin collection with timeout, issue
// handshake to the change datapath, and one-cycle refund on abort.
module ticket_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic                      clk,
  input  logic                      rd,
  ticket_sequencer_if.slave         bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    COLLECT  = 3'd2,
    ISSUE    = 3'd3,
    WAIT_ACK = 3'd4,
    REFUND   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dest_q, dest_d;
  logic [1:0] qua_q, qua_d;
  logic [3:0] cost_q, cost_d;
  logic [3:0] coin_q, coin_d;
  logic [7:0] idle_q, idle_d;
  logic       reject_q, reject_d;

  logic [3:0] fare;
  logic [3:0] cost_calc;
  logic [4:0] coin_sum;
  logic       coin_ok;
  logic [8:0] idle_inc;

  always_comb begin
    case (bus.dest_sel)
      2'd1:    fare = 4'd2;
      2'd2:    fare = 4'd3;
      2'd3:    fare = 4'd4;
      default: fare = 4'd0;
    endcase
  end

  // Largest product is 4 x 3 = 12, so 4 bits never overflow.
  assign cost_calc = fare * {2'b00, bus.qua_sel};
  assign coin_sum  = {1'b0, coin_q} + {1'b0, bus.coin_value};
  assign coin_ok   = (bus.coin_value != 4'd0) && (coin_sum <= 5'd15);
  assign idle_inc  = {1'b0, idle_q} + 9'd1;

  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      qua_q    <= '0;
      cost_q   <= '0;
      coin_q   <= '0;
      idle_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      qua_q    <= qua_d;
      cost_q   <= cost_d;
      coin_q   <= coin_d;
      idle_q   <= idle_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    qua_d    = qua_q;
    cost_d   = cost_q;
    coin_d   = coin_q;
    idle_d   = idle_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SELECT;
      end
      SELECT: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (bus.sel_valid && bus.dest_sel != 2'd0 && bus.qua_sel != 2'd0) begin
          dest_d  = bus.dest_sel;
          qua_d   = bus.qua_sel;
          cost_d  = cost_calc;
          coin_d  = 4'd0;
          idle_d  = 8'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // A coin arriving while leaving COLLECT is refused so it is returned.
        if (bus.cancel) begin
          state_d  = REFUND;
          reject_d = bus.coin_valid;
        end else if (coin_q >= cost_q) begin
          state_d  = ISSUE;
          reject_d = bus.coin_valid;
        end else if (bus.coin_valid && coin_ok) begin
          coin_d = coin_sum[3:0];
          idle_d = 8'd0;
        end else begin
          reject_d = bus.coin_valid;
          idle_d   = idle_inc[7:0];
          if (idle_inc == 9'(TIMEOUT_CYC)) state_d = REFUND;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.act_1) begin
          state_d = IDLE;
          dest_d  = 2'd0;
          qua_d   = 2'd0;
          cost_d  = 4'd0;
          coin_d  = 4'd0;
        end
      end
      REFUND: begin
        state_d = IDLE;
        dest_d  = 2'd0;
        qua_d   = 2'd0;
        cost_d  = 4'd0;
        coin_d  = 4'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is a function of registers only.
  assign bus.state          = state_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.destination_in = dest_q;
  assign bus.qua_in         = qua_q;
  assign bus.cost_in        = cost_q;
  assign bus.coin_in        = coin_q;
  assign bus.finish         = (state_q == ISSUE) || (state_q == WAIT_ACK);
  assign bus.refund_valid   = (state_q == REFUND);
  assign bus.refund         = (state_q == REFUND) ? coin_q : 4'd0;
  assign bus.coin_reject    = reject_q;

endmodule

// File: tb/tb_ticket_sequencer.sv
// Directed bench for ticket_sequencer: a vector table for the main flows plus
// hand-written timeout and asynchronous-reset sequences.
module tb_ticket_sequencer;

  localparam int unsigned T_CYC = 10;

  logic clk = 1'b0;
  logic rd  = 1'b0;
  always #5 clk = ~clk;

  ticket_sequencer_if bus();

  ticket_sequencer #(.TIMEOUT_CYC(T_CYC)) dut (
    .clk (clk),
    .rd  (rd),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       sel_v;
    logic [1:0] dest;
    logic [1:0] qua;
    logic       coin_v;
    logic [3:0] coin_val;
    logic       cancel;
    logic       act;
    logic [2:0] e_state;
    logic [1:0] e_dest;
    logic [1:0] e_qua;
    logic [3:0] e_cost;
    logic [3:0] e_coin;
    logic       e_fin;
    logic       e_rej;
    logic [3:0] e_refund;
    logic       e_rv;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.sel_valid = 1'b0; bus.dest_sel = 2'd0; bus.qua_sel = 2'd0;
    bus.coin_valid = 1'b0; bus.coin_value = 4'd0; bus.cancel = 1'b0; bus.act_1 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.start = v.start; bus.sel_valid = v.sel_v; bus.dest_sel = v.dest; bus.qua_sel = v.qua;
    bus.coin_valid = v.coin_v; bus.coin_value = v.coin_val; bus.cancel = v.cancel; bus.act_1 = v.act;
  endtask

  function automatic logic [22:0] pack_dut();
    return {bus.state, bus.destination_in, bus.qua_in, bus.cost_in, bus.coin_in,
            bus.finish, bus.coin_reject, bus.refund, bus.refund_valid, bus.busy};
  endfunction

  function automatic logic [22:0] pack_exp(input vec_t v);
    return {v.e_state, v.e_dest, v.e_qua, v.e_cost, v.e_coin,
            v.e_fin, v.e_rej, v.e_refund, v.e_rv, (v.e_state != 3'd0)};
  endfunction

  initial begin
    // inputs: start sel_v dest qua coin_v coin_val cancel act | expected after the edge
    // Basic purchase: fare 2 x 3 = 6, coins 5 + 4, act_1 early is ignored.
    vecs.push_back('{1'b1,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd1,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b1,1'b1,2'd0,2'd1,1'b0,4'd0,1'b0,1'b0, 3'd1,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b1,2'd1,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd1,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b1,2'd1,2'd3,1'b0,4'd0,1'b0,1'b0, 3'd2,2'd1,2'd3,4'd6, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd5,1'b0,1'b0, 3'd2,2'd1,2'd3,4'd6, 4'd5, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd4,1'b0,1'b1, 3'd2,2'd1,2'd3,4'd6, 4'd9, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd3,2'd1,2'd3,4'd6, 4'd9, 1'b1,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b1,1'b0, 3'd4,2'd1,2'd3,4'd6, 4'd9, 1'b1,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b1,1'b0, 3'd4,2'd1,2'd3,4'd6, 4'd9, 1'b1,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b1,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd4,2'd1,2'd3,4'd6, 4'd9, 1'b1,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b1, 3'd0,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd3,1'b0,1'b0, 3'd0,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    // Cancel during collection: fare 4 x 3 = 12, coins 4 + 4, cancel with a coin.
    vecs.push_back('{1'b1,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd1,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b1,2'd3,2'd3,1'b0,4'd0,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd4,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd4, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd4,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd8, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd2,1'b1,1'b0, 3'd5,2'd3,2'd3,4'd12,4'd8, 1'b0,1'b1,4'd8,1'b1});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd0,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    // Overflow and zero coins are refused; coin 5 on reaching 12 is refused too.
    vecs.push_back('{1'b1,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd1,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b1,2'd3,2'd3,1'b0,4'd0,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd5,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd5, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd5,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd10,1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd6,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd10,1'b0,1'b1,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd0,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd10,1'b0,1'b1,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd10,1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd2,1'b0,1'b0, 3'd2,2'd3,2'd3,4'd12,4'd12,1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b1,4'd5,1'b0,1'b0, 3'd3,2'd3,2'd3,4'd12,4'd12,1'b1,1'b1,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd4,2'd3,2'd3,4'd12,4'd12,1'b1,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b1, 3'd0,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    // Cancel in SELECT returns straight to IDLE.
    vecs.push_back('{1'b1,1'b0,2'd0,2'd0,1'b0,4'd0,1'b0,1'b0, 3'd1,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});
    vecs.push_back('{1'b0,1'b0,2'd0,2'd0,1'b0,4'd0,1'b1,1'b0, 3'd0,2'd0,2'd0,4'd0, 4'd0, 1'b0,1'b0,4'd0,1'b0});

    clear_inputs();
    #12;
    check("reset_outputs", 32'(pack_dut()), 32'd0);
    @(negedge clk);
    rd = 1'b1;
    step();
    check("post_reset_idle", 32'(pack_dut()), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d", i), 32'(pack_dut()), 32'(pack_exp(vecs[i])));
    end
    clear_inputs();

    // Inactivity timeout: fare 2 x 3 = 6, one coin of 2, then nothing.
    bus.start = 1'b1; step(); clear_inputs();
    bus.sel_valid = 1'b1; bus.dest_sel = 2'd1; bus.qua_sel = 2'd3; step(); clear_inputs();
    bus.coin_valid = 1'b1; bus.coin_value = 4'd2; step(); clear_inputs();
    check("to_coin", 32'({bus.state, bus.coin_in}), 32'({3'd2, 4'd2}));
    begin
      int n = 0;
      while (!bus.refund_valid && n < 50) begin
        step();
        n++;
      end
      check("to_cycles", 32'(n), 32'(T_CYC));
    end
    check("to_refund", 32'({bus.refund_valid, bus.refund, bus.state}), 32'({1'b1, 4'd2, 3'd5}));
    step();
    check("to_idle", 32'(pack_dut()), 32'd0);

    // Asynchronous reset while waiting for the datapath acknowledge.
    bus.start = 1'b1; step(); clear_inputs();
    bus.sel_valid = 1'b1; bus.dest_sel = 2'd2; bus.qua_sel = 2'd1; step(); clear_inputs();
    check("ra_cost", 32'(bus.cost_in), 32'd3);
    bus.coin_valid = 1'b1; bus.coin_value = 4'd3; step(); clear_inputs();
    step();
    step();
    check("ra_wait", 32'({bus.state, bus.finish, bus.coin_in}), 32'({3'd4, 1'b1, 4'd3}));
    #3;
    rd = 1'b0;
    #1;
    check("rst_async", 32'(pack_dut()), 32'd0);
    step();
    check("rst_held", 32'(pack_dut()), 32'd0);
    #2;
    rd = 1'b1;
    bus.start = 1'b1;
    #1;
    check("rst_release_hold", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rst_restart", 32'({bus.state, bus.busy}), 32'({3'd1, 1'b1}));
    bus.cancel = 1'b1; step(); clear_inputs();
    check("rst_cancel_idle", 32'(pack_dut()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
